thread_issue_sched: RTL



---
 rtl/thread_issue_sched_pkg.sv | 37 +++
 rtl/thread_issue_sched_nxt.sv | 15 +
 rtl/thread_issue_sched.sv | 130 +++++++++++++
 3 files changed

// File: rtl/thread_issue_sched_pkg.sv
// Shared definitions for the sha512 thread issue scheduler: thread_num field
// layout {core, ctx, seq}, width helper, and the engine's fixed thread order.
package thread_issue_sched_pkg;

  localparam int SEQ_BIT  = 0;
  localparam int CTX_BIT  = 1;
  localparam int CORE_LSB = 2;

  typedef enum logic {
    SCAN  = 1'b0,
    OFFER = 1'b1
  } sched_state_e;

  function automatic int msb_of(input int v);
    if (v <= 1) return 0;
    return $clog2(v + 1) - 1;
  endfunction

  function automatic int tn_w(input int n_cores);
    return msb_of(n_cores - 1) + 3;
  endfunction

  // Core advances fastest; ctx flips on core wrap; seq flips when ctx wraps 1->0.
  function automatic logic [31:0] nxt_thread(input logic [31:0] t, input int n_cores);
    logic [31:0] c;
    logic        x;
    logic        s;
    logic        wrap;
    c    = t >> CORE_LSB;
    x    = t[CTX_BIT];
    s    = t[SEQ_BIT];
    wrap = (c == 32'(n_cores - 1));
    return ((wrap ? 32'd0 : c + 32'd1) << CORE_LSB)
         | {30'd0, (wrap ? ~x : x), ((wrap & x) ? ~s : s)};
  endfunction

endpackage

// File: rtl/thread_issue_sched_nxt.sv
// Next-thread combinational block: maps a thread number to its successor in
// the engine's fixed issue order.
module thread_issue_sched_nxt
  import thread_issue_sched_pkg::*;
#(
  parameter int N_CORES = 3,
  parameter int TN_W    = tn_w(N_CORES)
) (
  input  logic [TN_W-1:0] t,
  output logic [TN_W-1:0] t_nxt
);

  assign t_nxt = TN_W'(nxt_thread(32'(t), N_CORES));

endmodule

// File: rtl/thread_issue_sched.sv
// Per-engine sha512 thread issue scheduler: scans threads in engine order and
// offers eligible ones, tracking in-flight threads in a busy mask.
// Optional stall counter output enabled by THREAD_ISSUE_SCHED_STATS_EN.
module thread_issue_sched
  import thread_issue_sched_pkg::*;
#(
  parameter int N_CORES = 3,
  localparam int TN_W   = tn_w(N_CORES),
  localparam int N_TV   = 2 ** TN_W
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [N_TV-1:0] thread_ready,
  output logic            issue_valid,
  output logic [TN_W-1:0] issue_thread,
  input  logic            issue_accept,
  input  logic            done_valid,
  input  logic [TN_W-1:0] done_thread,
  output logic [N_TV-1:0] busy,
  output logic            err
`ifdef THREAD_ISSUE_SCHED_STATS_EN
 ,output logic [31:0]     stall_cnt
`endif
);

  sched_state_e    state_q, state_d;
  logic [TN_W-1:0] ptr_q, ptr_d;
  logic            issue_valid_q, issue_valid_d;
  logic [TN_W-1:0] issue_thread_q, issue_thread_d;
  logic [N_TV-1:0] busy_q, busy_d;
  logic            err_q, err_d;
  logic [TN_W-1:0] ptr_nxt;
  logic [TN_W-1:0] issue_nxt;
  logic            done_core_bad;

  thread_issue_sched_nxt #(.N_CORES(N_CORES), .TN_W(TN_W)) u_scan_nxt (
    .t     (ptr_q),
    .t_nxt (ptr_nxt)
  );

  thread_issue_sched_nxt #(.N_CORES(N_CORES), .TN_W(TN_W)) u_issue_nxt (
    .t     (issue_thread_q),
    .t_nxt (issue_nxt)
  );

  assign done_core_bad = 32'(done_thread[TN_W-1:CORE_LSB]) >= 32'(N_CORES);

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    issue_valid_d  = issue_valid_q;
    issue_thread_d = issue_thread_q;
    busy_d         = busy_q;
    err_d          = err_q;

    // Done is applied first so a same-cycle transfer's busy set wins.
    if (done_valid) begin
      if (done_core_bad || !busy_q[done_thread]) begin
        err_d = 1'b1;
      end else begin
        busy_d[done_thread] = 1'b0;
      end
    end

    case (state_q)
      SCAN: begin
        if (thread_ready[ptr_q] && !busy_q[ptr_q]) begin
          issue_thread_d = ptr_q;
          issue_valid_d  = 1'b1;
          state_d        = OFFER;
        end else begin
          ptr_d = ptr_nxt;
        end
      end
      OFFER: begin
        if (issue_accept) begin
          busy_d[issue_thread_q] = 1'b1;
          ptr_d                  = issue_nxt;
          issue_valid_d          = 1'b0;
          state_d                = SCAN;
          if (done_valid && done_thread == issue_thread_q) err_d = 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q        <= SCAN;
      ptr_q          <= '0;
      issue_valid_q  <= 1'b0;
      issue_thread_q <= '0;
      busy_q         <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      issue_valid_q  <= issue_valid_d;
      issue_thread_q <= issue_thread_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  assign issue_valid  = issue_valid_q;
  assign issue_thread = issue_thread_q;
  assign busy         = busy_q;
  assign err          = err_q;

`ifdef THREAD_ISSUE_SCHED_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts idle scan cycles and offers the engine did not take; saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == SCAN || !issue_accept) && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
